// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) for the MEM/WB boundary.
// in_ready_o depends only on registered occupancy and stall, so out_ready_i never reaches it combinationally.
module pipe_skid_reg #(
  parameter int DATA_W         = 69,
  parameter int CTRL_W         = 2,
  parameter bit FLUSH_CLR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;

  logic in_ready, out_valid, accept, pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      // Control is always squashed so no stale RegWrite survives; data only if configured.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (FLUSH_CLR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (!stall_i) begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl_i;
            main_data_d = in_data_i;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl_i;
            skid_data_d = in_data_i;
            state_d     = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready    = (state_q != FULL) && !stall_i;
    out_valid   = (state_q != EMPTY) && !stall_i;
    accept      = in_valid_i && in_ready;
    pop         = out_valid && out_ready_i;
    in_ready_o  = in_ready;
    out_valid_o = out_valid;
    out_ctrl_o  = out_valid ? main_ctrl_q : '0;
    out_data_o  = main_data_q;
    count_o     = state_q;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed + random bench for pipe_skid_reg: a default instance and a narrow
// instance that clears data on flush, both checked against a 2-deep queue model.
module tb_pipe_skid_reg;
  localparam int DW = 69;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, stall, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy0, vld0;
  logic [CW-1:0] octrl0;
  logic [DW-1:0] odata0;
  logic [1:0]    cnt0;

  logic          rdy1, vld1;
  logic [0:0]    octrl1;
  logic [7:0]    odata1;
  logic [1:0]    cnt1;

  pipe_skid_reg dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(vld0), .out_ready_i(out_ready), .out_ctrl_o(octrl0), .out_data_o(odata0),
    .count_o(cnt0)
  );

  pipe_skid_reg #(.DATA_W(8), .CTRL_W(1), .FLUSH_CLR_DATA(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_ctrl_i(in_ctrl[0:0]), .in_data_i(in_data[7:0]),
    .out_valid_o(vld1), .out_ready_i(out_ready), .out_ctrl_o(octrl1), .out_data_o(odata1),
    .count_o(cnt1)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        sb[$];
  ent_t        main0, main1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic ent_t mk(input int unsigned n);
    ent_t e;
    e.c = CW'(n) | CW'(1);
    e.d = {5'(n), 32'hA5A5_0000 | 32'(n), 32'h5A5A_0000 | 32'(n)};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev, er;
    ev = (sb.size() != 0) && !stall;
    er = (sb.size() < 2) && !stall;
    chk("valid0", DW'(vld0), DW'(ev));
    chk("ready0", DW'(rdy0), DW'(er));
    chk("count0", DW'(cnt0), DW'(sb.size()));
    chk("ctrl0",  DW'(octrl0), ev ? DW'(main0.c) : '0);
    chk("data0",  odata0, main0.d);
    chk("valid1", DW'(vld1), DW'(ev));
    chk("ready1", DW'(rdy1), DW'(er));
    chk("count1", DW'(cnt1), DW'(sb.size()));
    chk("ctrl1",  DW'(octrl1), ev ? DW'(main1.c[0]) : '0);
    chk("data1",  DW'(odata1), DW'(main1.d[7:0]));
  endtask

  task automatic reset_checks(input logic st);
    chk("rst_valid0", DW'(vld0), '0);
    chk("rst_ready0", DW'(rdy0), DW'(!st));
    chk("rst_ctrl0",  DW'(octrl0), '0);
    chk("rst_data0",  odata0, '0);
    chk("rst_count0", DW'(cnt0), '0);
    chk("rst_valid1", DW'(vld1), '0);
    chk("rst_ready1", DW'(rdy1), DW'(!st));
    chk("rst_data1",  DW'(odata1), '0);
    chk("rst_count1", DW'(cnt1), '0);
  endtask

  // Drive one cycle, check before the edge, then advance the reference queue.
  task automatic step(input logic v, input ent_t e, input logic ordy, input logic st, input logic fl);
    logic ac, pp;
    in_valid  = v;
    in_ctrl   = e.c;
    in_data   = e.d;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (fl) begin
      sb.delete();
      main0.c = '0;
      main1   = '0;
    end else if (!st) begin
      ac = v && (sb.size() < 2);
      pp = (sb.size() != 0) && ordy;
      if (pp) void'(sb.pop_front());
      if (ac) sb.push_back(e);
    end
    if (sb.size() != 0) begin
      main0 = sb[0];
      main1 = sb[0];
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    ent_t a, b, c, d, e;
    a = mk(1); b = mk(2); c = mk(3); d = mk(4); e = mk(5);
    main0 = '0; main1 = '0;

    rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #2 reset_checks(1'b0);
    stall = 1'b1;
    #1 reset_checks(1'b1);
    stall = 1'b0; in_valid = 1'b1; in_ctrl = a.c; in_data = a.d;
    @(posedge clk); #1;
    reset_checks(1'b0);
    rst = 1'b0; in_valid = 1'b0;

    // streaming
    step(1'b1, a, 1'b1, 1'b0, 1'b0);
    step(1'b1, b, 1'b1, 1'b0, 1'b0);
    step(1'b1, c, 1'b1, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1);

    // backpressure
    step(1'b1, a, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // stall while full
    step(1'b1, a, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, c, 1'b1, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // flush from FULL under stall, then flush from ONE with an offered entry
    step(1'b1, a, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b1, c, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    step(1'b1, e, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // async reset between edges while FULL
    step(1'b1, a, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 reset_checks(stall);
    sb.delete(); main0 = '0; main1 = '0;
    #1 rst = 1'b0;
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 3) != 0), mk(16 + i), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(1'b1); idle(1'b1); idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 69, giving the width of the data payload (MEM/WB default: 32 memdata + 32 ALU result + 5 RD address).
REQ-002 The block SHALL have parameter CTRL_W, default 2, giving the width of the control payload (e.g. MemtoReg, RegWrite).
REQ-003 The block SHALL have parameter FLUSH_CLR_DATA, default 0; when 1, flush also zeroes the data registers.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock, all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous squash of all held entries.
REQ-007 The block SHALL have port stall_i, input, 1 bit: freeze, with no transfer in or out.
REQ-008 The block SHALL have port in_valid_i, input, 1 bit: upstream entry valid.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: block can accept an entry.
REQ-010 The block SHALL have port in_ctrl_i, input, CTRL_W bits: upstream control payload.
REQ-011 The block SHALL have port in_data_i, input, DATA_W bits: upstream data payload.
REQ-012 The block SHALL have port out_valid_o, output, 1 bit: head entry valid.
REQ-013 The block SHALL have port out_ready_i, input, 1 bit: downstream consumes the head entry.
REQ-014 The block SHALL have port out_ctrl_o, output, CTRL_W bits: head control payload.
REQ-015 The block SHALL have port out_data_o, output, DATA_W bits: head data payload.
REQ-016 The block SHALL have port count_o, output, 2 bits: occupancy, 0..2.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; count register encodes state EMPTY=0, ONE=1, FULL=2.
REQ-018 in_ready_o SHALL equal (count != 2) AND NOT stall_i, with no combinational path from out_ready_i.
REQ-019 out_valid_o SHALL equal (count != 0) AND NOT stall_i.
REQ-020 Accept SHALL be in_valid_i AND in_ready_o, and pop SHALL be out_valid_o AND out_ready_i; both evaluate to 0 during stall.
REQ-021 In EMPTY, accept SHALL load main and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-022 In ONE, accept with pop SHALL load main from the input and stay in ONE.
REQ-023 In ONE, accept without pop SHALL load skid and go to FULL.
REQ-024 In ONE, pop without accept SHALL go to EMPTY.
REQ-025 In FULL, pop SHALL move skid to main and go to ONE; otherwise the block SHALL hold FULL.
REQ-026 Entries SHALL leave in acceptance order, with no loss and no duplication.
REQ-027 Latency SHALL be 1 cycle: an entry accepted at edge N is presented on the outputs after edge N if the block was EMPTY, or if it was ONE with a pop at edge N.
REQ-028 out_ctrl_o SHALL be forced to all-zero whenever out_valid_o=0, so a bubble never asserts RegWrite or MemtoReg; out_data_o SHALL always show main.
REQ-029 stall_i=1 SHALL hold every register, including count, unchanged.
REQ-030 flush_i=1 SHALL have priority over stall_i and over accept/pop.
REQ-031 At the next edge, flush SHALL set count=0 and zero both control registers.
REQ-032 Data registers SHALL hold on flush, or zero on flush when FLUSH_CLR_DATA=1.
REQ-033 An entry offered in the flush cycle SHALL be discarded.
REQ-034 count_o SHALL reflect the count register directly (registered).

Reset
REQ-035 rst_i=1 SHALL immediately and asynchronously clear count, main, skid, and all control and data registers to 0.
REQ-036 While rst_i=1, outputs SHALL be out_valid_o=0, in_ready_o=NOT stall_i, out_ctrl_o=0, out_data_o=0, count_o=0.
REQ-037 Deassertion of rst_i SHALL leave the block EMPTY; reset mid-transfer SHALL drop all entries.

Verification
REQ-038 Streaming: out_ready_i=1, inputs A=0x..01, B=0x..02, C=0x..03 in consecutive cycles -> outputs A,B,C on consecutive cycles, count_o=1 throughout.
REQ-039 Backpressure: accept A, then B with out_ready_i=0 -> count_o=2, in_ready_o=0, out_data_o=A; raise out_ready_i -> A then B emerge, count_o steps 2->1->0.
REQ-040 Stall: FULL with A,B, stall_i=1 for 3 cycles with in_valid_i=1 and out_ready_i=1 -> out_valid_o=0, out_ctrl_o=0, in_ready_o=0, count_o=2 held; release -> A out next.
REQ-041 Flush: FULL, flush_i=1 with stall_i=1 and in_valid_i=1 -> next cycle count_o=0, out_ctrl_o=0; with FLUSH_CLR_DATA=1, out_data_o=0 as well.
REQ-042 Async reset: assert rst_i between edges while FULL -> count_o=0 and out_valid_o=0 before the next edge; first post-reset accept goes to main.
REQ-043 Parameters: DATA_W=8 and CTRL_W=1 rerunning REQ-038 and REQ-039 -> identical ordering and occupancy behaviour.
